// File: rtl/updown_pkg.sv
// Shared definitions for the up/down sweep sequencer and its counter datapath.
package updown_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Count direction encoding, as seen on the dir output
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Width of a prescaler that counts 0 .. div-1; never less than one bit
  function automatic int unsigned presc_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/updown_core.sv
// WIDTH-bit up/down counter datapath. A load overrides a pending step.
module updown_core
  import updown_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Next count: load first, otherwise step one in the requested direction
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      if (dir == DIR_UP) begin
        count_d = count_q + 1'b1;
      end else begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Counter register, cleared by the asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Triangular sweep sequencer: runs n sweeps lo -> hi -> lo on the counter
// datapath, one step every DIV clocks, with start/abort command handling.
module updown_sweep_ctrl
  import updown_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int SWEEP_W = 4,
  parameter int DIV     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   lo,
  input  logic [WIDTH-1:0]   hi,
  input  logic [SWEEP_W-1:0] n_sweeps,
  output logic [WIDTH-1:0]   count,
  output logic               dir,
  output logic               busy,
  output logic               done,
  output logic [SWEEP_W-1:0] sweep_cnt,
  output logic               cfg_err
);

  localparam int                 PRESC_W   = presc_width(DIV);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(DIV - 1);

  // Control state
  state_e             state_d,   state_q;
  logic               dir_d,     dir_q;
  logic               busy_d,    busy_q;
  logic               done_d,    done_q;
  logic               cfg_err_d, cfg_err_q;
  logic [SWEEP_W-1:0] sweep_d,   sweep_q;
  logic [PRESC_W-1:0] presc_d,   presc_q;

  // Run configuration captured on an accepted start
  logic [WIDTH-1:0]   lo_sh_d,   lo_sh_q;
  logic [WIDTH-1:0]   hi_sh_d,   hi_sh_q;
  logic [SWEEP_W-1:0] n_sh_d,    n_sh_q;

  // Datapath control and derived values
  logic               core_en;
  logic               core_load;
  logic [WIDTH-1:0]   core_load_val;
  logic [WIDTH-1:0]   count_w;
  logic [WIDTH-1:0]   step_val;
  logic [SWEEP_W-1:0] sweep_inc;
  logic [PRESC_W-1:0] presc_adv;
  logic               tick;

  updown_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .en       (core_en),
    .dir      (dir_q),
    .load     (core_load),
    .load_val (core_load_val),
    .count    (count_w)
  );

  // Value the counter will hold after a step, used to detect the turn points
  always_comb begin
    if (dir_q == DIR_UP) begin
      step_val = count_w + 1'b1;
    end else begin
      step_val = count_w - 1'b1;
    end
    sweep_inc = sweep_q + 1'b1;
    tick      = (presc_q == PRESC_MAX);
    presc_adv = tick ? '0 : presc_q + 1'b1;
  end

  // Sequencer next-state, datapath control and registered-output decode
  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    cfg_err_d     = 1'b0;
    sweep_d       = sweep_q;
    presc_d       = presc_q;
    lo_sh_d       = lo_sh_q;
    hi_sh_d       = hi_sh_q;
    n_sh_d        = n_sh_q;
    core_en       = 1'b0;
    core_load     = 1'b0;
    core_load_val = lo_sh_q;

    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        if (start) begin
          if (lo < hi) begin
            lo_sh_d       = lo;
            hi_sh_d       = hi;
            n_sh_d        = n_sweeps;
            core_load     = 1'b1;
            core_load_val = lo;
            dir_d         = DIR_UP;
            sweep_d       = '0;
            busy_d        = 1'b1;
            state_d       = ST_UP;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      ST_UP: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          presc_d = '0;
        end else begin
          presc_d = presc_adv;
          if (tick) begin
            core_en = 1'b1;
            if (step_val == hi_sh_q) begin
              state_d = ST_DOWN;
              dir_d   = DIR_DN;
              presc_d = '0;
            end
          end
        end
      end

      ST_DOWN: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          presc_d = '0;
        end else begin
          presc_d = presc_adv;
          if (tick) begin
            core_en = 1'b1;
            if (step_val == lo_sh_q) begin
              sweep_d = sweep_inc;
              presc_d = '0;
              // A zero sweep request never terminates on its own
              if ((n_sh_q != '0) && (sweep_inc == n_sh_q)) begin
                state_d = ST_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end else begin
                state_d = ST_UP;
                dir_d   = DIR_UP;
              end
            end
          end
        end
      end

      ST_DONE: begin
        state_d       = ST_IDLE;
        presc_d       = '0;
        core_load     = 1'b1;
        core_load_val = lo_sh_q;
        sweep_d       = n_sh_q;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        presc_d = '0;
      end
    endcase
  end

  // Control registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_UP;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      sweep_q   <= '0;
      presc_q   <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
      sweep_q   <= sweep_d;
      presc_q   <= presc_d;
    end
  end

  // Run configuration registers; only meaningful after an accepted start
  always_ff @(posedge clk) begin
    lo_sh_q <= lo_sh_d;
    hi_sh_q <= hi_sh_d;
    n_sh_q  <= n_sh_d;
  end

  assign count     = count_w;
  assign dir       = dir_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sweep_cnt = sweep_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Scoreboard bench for updown_sweep_ctrl: a DIV=1 and a DIV=3 instance share
// the same command stream; each has its own expected-output queue.
`timescale 1ns/1ps
module tb_updown_sweep_ctrl;

  localparam int W  = 4;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  lo = '0;
  logic [W-1:0]  hi = '0;
  logic [SW-1:0] n_sweeps = '0;

  logic [W-1:0]  count1, count3;
  logic          dir1, dir3, busy1, busy3, done1, done3, cfg1, cfg3;
  logic [SW-1:0] sw1, sw3;

  always #5 clk = ~clk;

  updown_sweep_ctrl #(.WIDTH(W), .SWEEP_W(SW), .DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .lo(lo), .hi(hi),
    .n_sweeps(n_sweeps), .count(count1), .dir(dir1), .busy(busy1),
    .done(done1), .sweep_cnt(sw1), .cfg_err(cfg1)
  );

  updown_sweep_ctrl #(.WIDTH(W), .SWEEP_W(SW), .DIV(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .lo(lo), .hi(hi),
    .n_sweeps(n_sweeps), .count(count3), .dir(dir3), .busy(busy3),
    .done(done3), .sweep_cnt(sw3), .cfg_err(cfg3)
  );

  typedef struct {
    int count;
    bit dir;
    bit dir_chk;
    bit busy;
    bit done;
    int sweep;
    bit cfg_err;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  int   errors = 0;
  int   checks = 0;
  int   hold_cnt[2];
  int   hold_sw[2];
  int   m_cnt[2];
  int   m_sw[2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents busy/done/cfg_err,
  // otherwise requires the idle hold values of the last presented output.
  task automatic monitor(input int id, input int cnt, input bit d, input bit b,
                         input bit dn, input int sw, input bit ce);
    exp_t  e;
    string p;
    bit    empty;
    p = (id == 0) ? "div1" : "div3";
    if (rst) begin
      check({p, "_rst_count"}, cnt, 0);
      check({p, "_rst_dir"}, int'(d), 1);
      check({p, "_rst_busy"}, int'(b), 0);
      check({p, "_rst_done"}, int'(dn), 0);
      check({p, "_rst_sweep"}, sw, 0);
      check({p, "_rst_cfg_err"}, int'(ce), 0);
      hold_cnt[id] = 0;
      hold_sw[id]  = 0;
    end else if (b || dn || ce) begin
      empty = (id == 0) ? (q1.size() == 0) : (q3.size() == 0);
      if (empty) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected_output: got busy=%0d done=%0d cfg_err=%0d count=%0d required no output at %0t",
                 p, b, dn, ce, cnt, $time);
      end else begin
        if (id == 0) e = q1.pop_front();
        else         e = q3.pop_front();
        check({p, "_count"}, cnt, e.count);
        if (e.dir_chk) check({p, "_dir"}, int'(d), int'(e.dir));
        check({p, "_busy"}, int'(b), int'(e.busy));
        check({p, "_done"}, int'(dn), int'(e.done));
        check({p, "_sweep_cnt"}, sw, e.sweep);
        check({p, "_cfg_err"}, int'(ce), int'(e.cfg_err));
        hold_cnt[id] = e.count;
        hold_sw[id]  = e.sweep;
      end
    end else begin
      check({p, "_idle_count"}, cnt, hold_cnt[id]);
      check({p, "_idle_sweep_cnt"}, sw, hold_sw[id]);
    end
  endtask

  always @(negedge clk) monitor(0, int'(count1), dir1, busy1, done1, int'(sw1), cfg1);
  always @(negedge clk) monitor(1, int'(count3), dir3, busy3, done3, int'(sw3), cfg3);

  task automatic push(input int id, input exp_t e);
    if (id == 0) q1.push_back(e);
    else         q3.push_back(e);
    m_cnt[id] = e.count;
    m_sw[id]  = e.sweep;
  endtask

  // Reference: the triangular trajectory computed by arithmetic on the cycle
  // offset t from the accepted start. A = abort offset, R = reset offset
  // (-1 = none). Returns the last offset at which the DUT presents output.
  task automatic push_run(input int id, input int div, input int l, input int h,
                          input int n, input int a, input int r, output int last);
    exp_t e;
    int   d, per, len, endt, s, u;
    if (l >= h) begin
      e.count = m_cnt[id]; e.dir = 1'b0; e.dir_chk = 1'b0; e.busy = 1'b0;
      e.done = 1'b0; e.sweep = m_sw[id]; e.cfg_err = 1'b1;
      push(id, e);
      last = 0;
      return;
    end
    d    = h - l;
    per  = 2 * d * div;
    len  = (n == 0) ? (1 << 30) : n * per;
    endt = len - 1;
    if (a >= 0 && a < endt) endt = a;
    if (r >= 0 && r - 1 < endt) endt = r - 1;
    for (int t = 0; t <= endt; t++) begin
      s = t / per;
      u = (t % per) / div;
      e.count   = (u < d) ? (l + u) : (h - (u - d));
      e.dir     = (u < d);
      e.dir_chk = 1'b1;
      e.busy    = 1'b1;
      e.done    = 1'b0;
      e.sweep   = s % (1 << SW);
      e.cfg_err = 1'b0;
      push(id, e);
    end
    last = endt;
    if (n != 0 && (a < 0 || a >= len) && (r < 0 || r > len)) begin
      e.count = l; e.dir = 1'b0; e.dir_chk = 1'b0; e.busy = 1'b0;
      e.done = 1'b1; e.sweep = n; e.cfg_err = 1'b0;
      push(id, e);
      last = len;
    end
    if (r >= 0) begin
      m_cnt[id] = 0;
      m_sw[id]  = 0;
    end
  endtask

  // Issue one start command and drive the run; noise scrambles the limit
  // inputs and pulses start while both instances are busy.
  task automatic do_run(input int l, input int h, input int n, input int a,
                        input int r, input bit noise);
    int last1, last3, safe, tend;
    @(posedge clk); #1;
    lo = W'(l); hi = W'(h); n_sweeps = SW'(n); start = 1'b1;
    push_run(0, 1, l, h, n, a, r, last1);
    push_run(1, 3, l, h, n, a, r, last3);
    @(posedge clk); #1;
    start = 1'b0;
    safe = (last1 < last3) ? last1 : last3;
    if (l >= h) safe = -1;
    tend = ((last1 > last3) ? last1 : last3) + 2;
    if (r >= 0) tend = r + 2;
    for (int t = 0; t <= tend; t++) begin
      abort = (t == a);
      if (noise) begin
        lo       = W'($urandom_range(0, 15));
        hi       = W'($urandom_range(0, 15));
        n_sweeps = SW'($urandom_range(0, 15));
        start    = (t <= safe && t != r) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (t == r) begin
        #1 rst = 1'b1;
      end else if (r >= 0 && t == r + 1) begin
        rst = 1'b0;
      end
      @(posedge clk); #1;
    end
    abort = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    int l, h, n, a, r;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_sw[i] = 0; hold_cnt[i] = 0; hold_sw[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    do_run(1, 6, 1, -1, 2, 1'b0);      // reset while count = 3 in UP
    do_run(2, 5, 1, -1, -1, 1'b0);     // single sweep
    do_run(5, 5, 1, -1, -1, 1'b0);     // lo == hi rejected
    do_run(9, 4, 1, -1, -1, 1'b0);     // lo > hi rejected
    do_run(0, 7, 2, 10, -1, 1'b0);     // abort at count 4 going down
    do_run(3, 9, 1, -1, -1, 1'b1);     // accepted after abort, inputs scrambled
    do_run(0, 15, 0, 485, -1, 1'b1);   // free-run past sweep_cnt wrap
    do_run(1, 3, 1, -1, -1, 1'b0);     // prescaler run on the DIV=3 instance

    for (int k = 0; k < 25; k++) begin
      l = $urandom_range(0, 15);
      h = $urandom_range(0, 15);
      n = $urandom_range(0, 3);
      a = -1;
      r = -1;
      if (l < h) begin
        if (n == 0) a = $urandom_range(0, 150);
        else if ($urandom_range(0, 1) == 1) a = $urandom_range(0, n * 2 * (h - l) * 3 + 2);
        if ($urandom_range(0, 7) == 0) r = $urandom_range(1, 40);
      end
      do_run(l, h, n, a, r, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("div1_queue_drained", q1.size(), 0);
    check("div3_queue_drained", q3.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
